// File: rtl/hazard_ctrl_fsm_if.sv
// ID/EX hazard inputs and PC / IF-ID / ID-EX control outputs of the hazard controller.
// The pipeline side uses master; the controller uses slave.
interface hazard_ctrl_fsm_if #(
  parameter int REG_W  = 5,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [REG_W-1:0]  rs_id;
  logic [REG_W-1:0]  rt_id;
  logic              rs_used_id;
  logic              rt_used_id;
  logic [REG_W-1:0]  rt_ex;
  logic              load_ex;
  logic              beq_id;
  logic              bne_id;
  logic              beq_ex;
  logic              bne_ex;
  logic              zero_alu;
  logic [ADDR_W-1:0] target_ex;

  logic              hold_pc;
  logic              if_id_hold;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_target;
  logic [CNT_W-1:0]  stall_cycles;
  logic              protocol_err;

  modport master (
    output rs_id, rt_id, rs_used_id, rt_used_id, rt_ex, load_ex,
           beq_id, bne_id, beq_ex, bne_ex, zero_alu, target_ex,
    input  hold_pc, if_id_hold, if_id_flush, id_ex_bubble, pc_redirect,
           pc_target, stall_cycles, protocol_err
  );

  modport slave (
    input  rs_id, rt_id, rs_used_id, rt_used_id, rt_ex, load_ex,
           beq_id, bne_id, beq_ex, bne_ex, zero_alu, target_ex,
    output hold_pc, if_id_hold, if_id_flush, id_ex_bubble, pc_redirect,
           pc_target, stall_cycles, protocol_err
  );
endinterface

// File: rtl/hazard_ctrl_fsm.sv
// Pipeline hazard controller: multi-cycle load-use bubbles, delayed beq/bne resolution
// with PC redirect, saturating stall counter and sticky protocol-error flag.
module hazard_ctrl_fsm #(
  parameter int REG_W             = 5,
  parameter int ADDR_W            = 32,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_DELAY      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_fsm_if.slave bus
);

  // Timer only needs to hold max(LOAD_STALL_CYCLES-2, BRANCH_DELAY-1).
  localparam int TMR_MAX = (LOAD_STALL_CYCLES > BRANCH_DELAY) ? LOAD_STALL_CYCLES : BRANCH_DELAY;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TW-1:0] LOAD_RELOAD = TW'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);
  localparam logic [TW-1:0] BR_RELOAD   = TW'((BRANCH_DELAY > 1) ? (BRANCH_DELAY - 1) : 0);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_WAIT    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [TW-1:0]     tmr_reg, tmr_next;
  logic [CNT_W-1:0]  stall_reg;
  logic              perr_reg;
  logic              perr_set;

  logic [REG_W-1:0]  rs_id, rt_id, rt_ex;
  logic [ADDR_W-1:0] target_ex;
  logic              load_use;
  logic              taken;

  logic              hold_pc;
  logic              if_id_hold;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_target;

  assign rs_id     = bus.rs_id;
  assign rt_id     = bus.rt_id;
  assign rt_ex     = bus.rt_ex;
  assign target_ex = bus.target_ex;

  // $zero is never a real dependency, so a load into it cannot cause a hazard.
  assign load_use = bus.load_ex && (rt_ex != '0) &&
                    ((bus.rs_used_id && (rs_id == rt_ex)) ||
                     (bus.rt_used_id && (rt_id == rt_ex)));

  assign taken = (bus.beq_ex && bus.zero_alu) || (bus.bne_ex && !bus.zero_alu);

  always_comb begin
    state_next   = state_reg;
    tmr_next     = tmr_reg;
    hold_pc      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = '0;
    perr_set     = 1'b0;
    if (!rst) begin
      case (state_reg)
        RUN: begin
          // Load-use wins; a branch in IF/ID simply waits there until the stall ends.
          if (load_use) begin
            hold_pc      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = LOAD_STALL;
              tmr_next   = LOAD_RELOAD;
            end
          end else if (bus.beq_id || bus.bne_id) begin
            hold_pc     = 1'b1;
            if_id_flush = 1'b1;
            state_next  = BR_WAIT;
            tmr_next    = BR_RELOAD;
          end
        end
        LOAD_STALL: begin
          hold_pc      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          if (tmr_reg == '0) begin
            state_next = RUN;
          end else begin
            tmr_next = tmr_reg - TW'(1);
          end
        end
        BR_WAIT: begin
          if (tmr_reg != '0) begin
            hold_pc     = 1'b1;
            if_id_flush = 1'b1;
            tmr_next    = tmr_reg - TW'(1);
          end else begin
            // Resolution: a taken branch squashes the fall-through and redirects.
            if (taken) begin
              pc_redirect = 1'b1;
              pc_target   = target_ex;
              if_id_flush = 1'b1;
            end
            perr_set   = !bus.beq_ex && !bus.bne_ex;
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          tmr_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      tmr_reg   <= '0;
      stall_reg <= '0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      if ((hold_pc || if_id_hold) && (stall_reg != {CNT_W{1'b1}})) begin
        stall_reg <= stall_reg + CNT_W'(1);
      end
      if (perr_set) begin
        perr_reg <= 1'b1;
      end
    end
  end

  assign bus.hold_pc      = hold_pc;
  assign bus.if_id_hold   = if_id_hold;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.pc_redirect  = pc_redirect;
  assign bus.pc_target    = pc_target;
  assign bus.stall_cycles = rst ? '0 : stall_reg;
  assign bus.protocol_err = !rst && perr_reg;

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// Drives three differently parametrised hazard controllers with the same stimulus and
// checks every output each cycle against a cycle-budget reference model.
module tb_hazard_ctrl_fsm;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_id, rt_id, rt_ex;
  logic        rs_used_id, rt_used_id, load_ex;
  logic        beq_id, bne_id, beq_ex, bne_ex, zero_alu;
  logic [31:0] target_ex;

  logic [4:0]  o_ctl [N];
  logic [31:0] o_tgt [N];
  logic [15:0] o_cnt [N];
  logic        o_perr [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: remaining stall cycles, remaining branch-hold cycles, counters.
  int m_stall_left [N];
  int m_br_left [N];
  bit m_br_act [N];
  bit m_perr [N];
  int m_cnt [N];

  function automatic int lsc_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction
  function automatic int bd_of(int i);
    return (i == 0) ? 1 : 2;
  endfunction
  function automatic int cmax_of(int i);
    return (i == 2) ? 7 : 65535;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LSC = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
    localparam int BD  = (gi == 0) ? 1 : 2;
    localparam int CW  = (gi == 2) ? 3 : 16;
    hazard_ctrl_fsm_if #(.REG_W(5), .ADDR_W(32), .CNT_W(CW)) bus ();
    assign bus.rs_id      = rs_id;
    assign bus.rt_id      = rt_id;
    assign bus.rs_used_id = rs_used_id;
    assign bus.rt_used_id = rt_used_id;
    assign bus.rt_ex      = rt_ex;
    assign bus.load_ex    = load_ex;
    assign bus.beq_id     = beq_id;
    assign bus.bne_id     = bne_id;
    assign bus.beq_ex     = beq_ex;
    assign bus.bne_ex     = bne_ex;
    assign bus.zero_alu   = zero_alu;
    assign bus.target_ex  = target_ex;
    hazard_ctrl_fsm #(
      .REG_W(5), .ADDR_W(32), .LOAD_STALL_CYCLES(LSC), .BRANCH_DELAY(BD), .CNT_W(CW)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
    assign o_ctl[gi]  = {bus.hold_pc, bus.if_id_hold, bus.if_id_flush, bus.id_ex_bubble, bus.pc_redirect};
    assign o_tgt[gi]  = bus.pc_target;
    assign o_cnt[gi]  = 16'(bus.stall_cycles);
    assign o_perr[gi] = bus.protocol_err;
  end

  // Control vector bits: {hold_pc, if_id_hold, if_id_flush, id_ex_bubble, pc_redirect}
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_BR    = 5'b10100;
  localparam logic [4:0] C_TAKEN = 5'b00101;

  task automatic tick();
    logic [4:0]  ec;
    logic [31:0] et;
    bit lu;
    bit tk;
    @(negedge clk);
    lu = load_ex && (rt_ex != 0) &&
         ((rs_used_id && rs_id == rt_ex) || (rt_used_id && rt_id == rt_ex));
    tk = (beq_ex && zero_alu) || (bne_ex && !zero_alu);
    for (int i = 0; i < N; i++) begin
      ec = '0;
      et = '0;
      if (!rst) begin
        if (m_stall_left[i] > 0) ec = C_STALL;
        else if (m_br_act[i]) begin
          if (m_br_left[i] > 0) ec = C_BR;
          else if (tk) begin
            ec = C_TAKEN;
            et = target_ex;
          end
        end else if (lu) ec = C_STALL;
        else if (beq_id || bne_id) ec = C_BR;
      end
      checks++;
      assert (o_ctl[i] === ec) else begin
        errors++;
        $error("FAIL ctrl inst=%0d cyc=%0d got=%b expected=%b", i, cyc, o_ctl[i], ec);
      end
      checks++;
      assert (o_tgt[i] === et) else begin
        errors++;
        $error("FAIL pc_target inst=%0d cyc=%0d got=%h expected=%h", i, cyc, o_tgt[i], et);
      end
      checks++;
      assert (o_cnt[i] === 16'(rst ? 0 : m_cnt[i])) else begin
        errors++;
        $error("FAIL stall_cycles inst=%0d cyc=%0d got=%0d expected=%0d", i, cyc, o_cnt[i], rst ? 0 : m_cnt[i]);
      end
      checks++;
      assert (o_perr[i] === (!rst && m_perr[i])) else begin
        errors++;
        $error("FAIL protocol_err inst=%0d cyc=%0d got=%b expected=%b", i, cyc, o_perr[i], !rst && m_perr[i]);
      end
      // Advance the model to what the next clock edge should produce.
      if (rst) begin
        m_stall_left[i] = 0;
        m_br_left[i]    = 0;
        m_br_act[i]     = 0;
        m_perr[i]       = 0;
        m_cnt[i]        = 0;
      end else begin
        if ((ec[4] || ec[3]) && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
        if (m_stall_left[i] > 0) m_stall_left[i]--;
        else if (m_br_act[i]) begin
          if (m_br_left[i] > 0) m_br_left[i]--;
          else begin
            m_br_act[i] = 0;
            if (!beq_ex && !bne_ex) m_perr[i] = 1;
          end
        end else if (lu) m_stall_left[i] = lsc_of(i) - 1;
        else if (beq_id || bne_id) begin
          m_br_act[i]  = 1;
          m_br_left[i] = bd_of(i) - 1;
        end
      end
    end
    $display("cyc=%0d rst=%b ld=%b bid=%b/%b bex=%b/%b z=%b ctl=%b/%b/%b cnt=%0d/%0d/%0d",
             cyc, rst, load_ex, beq_id, bne_id, beq_ex, bne_ex, zero_alu,
             o_ctl[0], o_ctl[1], o_ctl[2], o_cnt[0], o_cnt[1], o_cnt[2]);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs_id = '0; rt_id = '0; rt_ex = '0;
    rs_used_id = 1'b0; rt_used_id = 1'b0; load_ex = 1'b0;
    beq_id = 1'b0; bne_id = 1'b0; beq_ex = 1'b0; bne_ex = 1'b0; zero_alu = 1'b0;
    target_ex = '0;
    for (int i = 0; i < N; i++) begin
      m_stall_left[i] = 0; m_br_left[i] = 0; m_br_act[i] = 0; m_perr[i] = 0; m_cnt[i] = 0;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Load-use on rs
    load_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd5; rs_used_id = 1'b1;
    tick();
    load_ex = 1'b0;
    repeat (4) tick();

    // Load into $zero: no hazard
    load_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0;
    tick();
    load_ex = 1'b0;
    tick();

    // beq taken to 0x40
    beq_id = 1'b1;
    tick();
    beq_id = 1'b0; beq_ex = 1'b1; zero_alu = 1'b1; target_ex = 32'h40;
    repeat (3) tick();
    beq_ex = 1'b0;
    tick();

    // bne not taken
    bne_id = 1'b1;
    tick();
    bne_id = 1'b0; bne_ex = 1'b1; zero_alu = 1'b1; target_ex = 32'h80;
    repeat (3) tick();
    bne_ex = 1'b0; zero_alu = 1'b0;
    tick();

    // Load-use plus beq in ID; branch missing in EX at resolution
    load_ex = 1'b1; rt_ex = 5'd7; rt_id = 5'd7; rt_used_id = 1'b1; rs_used_id = 1'b0; beq_id = 1'b1;
    tick();
    load_ex = 1'b0;
    repeat (4) tick();
    beq_id = 1'b0;
    repeat (6) tick();

    // Reset pulsed in the middle of a load stall
    load_ex = 1'b1; rt_ex = 5'd3; rs_id = 5'd3; rs_used_id = 1'b1;
    tick();
    load_ex = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      rs_id      = 5'($urandom_range(0, 3));
      rt_id      = 5'($urandom_range(0, 3));
      rt_ex      = 5'($urandom_range(0, 3));
      rs_used_id = 1'($urandom_range(0, 1));
      rt_used_id = 1'($urandom_range(0, 1));
      load_ex    = ($urandom_range(0, 2) == 0);
      beq_id     = ($urandom_range(0, 3) == 0);
      bne_id     = ($urandom_range(0, 3) == 0);
      beq_ex     = 1'($urandom_range(0, 1));
      bne_ex     = ($urandom_range(0, 3) == 0);
      zero_alu   = 1'($urandom_range(0, 1));
      target_ex  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
